// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared pixel/window types, widths and window index helper
package window_gen_pkg;
    localparam int WIN_SIZE = 5;
    localparam int DATA_W   = 8;
    localparam int PIXEL_W  = 3 * DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] red;
        logic [DATA_W-1:0] green;
        logic [DATA_W-1:0] blue;
    } pixel_t;

    typedef pixel_t [WIN_SIZE*WIN_SIZE-1:0] window_t;

    function automatic int win_idx(input int r, input int c, input int ws);
        return r * ws + c;
    endfunction
endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel-in and window-out valid/ready handshakes
import window_gen_pkg::*;

interface window_gen_if #(
    parameter int PIXEL_W = window_gen_pkg::PIXEL_W,
    parameter int WIN_W   = WIN_SIZE * WIN_SIZE * window_gen_pkg::PIXEL_W
);
    logic [PIXEL_W-1:0] pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [WIN_W-1:0]   win_out;
    logic               win_valid;
    logic               win_ready;
    logic [15:0]        win_row;
    logic [15:0]        win_col;
    logic               frame_done;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_gen_line_buffer.sv
// window_gen_line_buffer: per-column store of the previous rows, async read, sync write
import window_gen_pkg::*;

module window_gen_line_buffer #(
    parameter int DEPTH = 229,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // store the up-shifted column; the async read above still sees the old contents this cycle
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/window_gen.sv
// window_gen: raster RGB stream to fully-interior WINDOW_SIZE x WINDOW_SIZE windows
import window_gen_pkg::*;

module window_gen #(
    parameter int WINDOW_SIZE = WIN_SIZE,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int img_width   = 229,
    parameter int img_height  = 229
) (
    input  logic        clk,
    input  logic        rst,
    window_gen_if.slave bus
);
    localparam int PW = 3 * DATA_WIDTH;
    localparam int WN = WINDOW_SIZE * WINDOW_SIZE;
    localparam int LW = (WINDOW_SIZE - 1) * PW;
    localparam int CW = $clog2(img_width);
    localparam int RW = $clog2(img_height);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [WN*PW-1:0] r_win;
    logic [WN*PW-1:0] w_win_next;
    logic [LW-1:0]    w_lb_rd;
    logic             r_valid;
    logic [15:0]      r_win_row;
    logic [15:0]      r_win_col;
    logic             w_pix_ready;
    logic             w_accept;
    logic             w_emit;
    logic             w_col_last;
    logic             w_row_last;

    assign w_pix_ready = !r_valid || bus.win_ready;
    assign w_accept    = bus.pix_valid && w_pix_ready;
    assign w_emit      = r_row >= RW'(WINDOW_SIZE - 1) && r_col >= CW'(WINDOW_SIZE - 1);
    assign w_col_last  = r_col == CW'(img_width - 1);
    assign w_row_last  = r_row == RW'(img_height - 1);

    assign bus.pix_ready  = w_pix_ready;
    assign bus.win_out    = r_win;
    assign bus.win_valid  = r_valid;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = r_valid && bus.win_ready &&
                            r_win_row == 16'(img_height - WINDOW_SIZE) &&
                            r_win_col == 16'(img_width - WINDOW_SIZE);

    // slot 0 holds the oldest row; each accept drops it and appends the incoming pixel
    window_gen_line_buffer #(.DEPTH(img_width), .WIDTH(LW)) u_lb (
        .clk    (clk),
        .i_we   (w_accept),
        .i_addr (r_col),
        .i_wdata({bus.pix_in, w_lb_rd[LW-1:PW]}),
        .o_rdata(w_lb_rd)
    );

    for (genvar r = 0; r < WINDOW_SIZE; r++) begin : g_row
        for (genvar c = 0; c < WINDOW_SIZE; c++) begin : g_col
            if (c < WINDOW_SIZE - 1) begin : g_shift
                assign w_win_next[win_idx(r, c, WINDOW_SIZE)*PW +: PW] =
                    r_win[win_idx(r, c + 1, WINDOW_SIZE)*PW +: PW];
            end else if (r < WINDOW_SIZE - 1) begin : g_lb
                assign w_win_next[win_idx(r, c, WINDOW_SIZE)*PW +: PW] = w_lb_rd[r*PW +: PW];
            end else begin : g_pix
                assign w_win_next[win_idx(r, c, WINDOW_SIZE)*PW +: PW] = bus.pix_in;
            end
        end
    end

    // raster counters, window shift and output register; a stalled window blocks input so it holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_win     <= '0;
            r_valid   <= 1'b0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else begin
            if (w_accept) begin
                r_win <= w_win_next;
                r_col <= w_col_last ? '0 : r_col + 1'b1;
                if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
            end
            if (w_accept && w_emit) begin
                r_valid   <= 1'b1;
                r_win_row <= 16'(r_row) - 16'(WINDOW_SIZE - 1);
                r_win_col <= 16'(r_col) - 16'(WINDOW_SIZE - 1);
            end else if (bus.win_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed checks of window_gen on an 8x6 ramp and a default 229x229 flat frame
import window_gen_pkg::*;

module tb_window_gen;
    localparam int WS = WIN_SIZE;
    localparam int WW = WS * WS * PIXEL_W;
    localparam int SW = 8;
    localparam int SH = 6;
    localparam int NC = SW - WS + 1;
    localparam int NS = NC * (SH - WS + 1);
    localparam int LD = 229;
    localparam int LC = LD - WS + 1;
    localparam int NL = LC * LC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    window_gen_if #(.PIXEL_W(PIXEL_W), .WIN_W(WW)) s_if ();
    window_gen_if #(.PIXEL_W(PIXEL_W), .WIN_W(WW)) l_if ();

    window_gen #(.img_width(SW), .img_height(SH)) u_small (.clk(clk), .rst(rst), .bus(s_if.slave));
    window_gen u_large (.clk(clk), .rst(rst), .bus(l_if.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_lat = 0;
    bit mon_s   = 0;
    bit mon_l   = 0;
    int s_n = 0, s_f = 0, s_tot = 0, s_fd = 0;
    int l_n = 0, l_tot = 0, l_fd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ramp(input int r, input int c, input int f);
        pixel_t p;
        p.red   = 8'(r + f);
        p.green = 8'(c + f);
        p.blue  = 8'((r ^ c) + f);
        return p;
    endfunction

    function automatic logic [WW-1:0] exp_win(input int wr, input int wc, input int f);
        logic [WW-1:0] w;
        for (int i = 0; i < WS; i++)
            for (int j = 0; j < WS; j++)
                w[(i*WS+j)*24 +: 24] = ramp(wr + i, wc + j, f);
        return w;
    endfunction

    always @(negedge clk) begin
        if (mon_s && s_if.frame_done) s_fd++;
        if (mon_s && s_if.win_valid && s_if.win_ready) begin
            chk("s_row", WW'(s_if.win_row), WW'(s_n / NC));
            chk("s_col", WW'(s_if.win_col), WW'(s_n % NC));
            chk("s_win", s_if.win_out, exp_win(s_n / NC, s_n % NC, s_f));
            chk("s_fdone", WW'(s_if.frame_done), WW'(s_n == NS - 1));
            s_tot++;
            s_n++;
            if (s_n == NS) begin
                s_n = 0;
                s_f++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_l && l_if.frame_done) l_fd++;
        if (mon_l && l_if.win_valid && l_if.win_ready) begin
            chk("l_row", WW'(l_if.win_row), WW'(l_n / LC));
            chk("l_col", WW'(l_if.win_col), WW'(l_n % LC));
            chk("l_win", l_if.win_out, {(WS*WS){24'h808080}});
            chk("l_fdone", WW'(l_if.frame_done), WW'(l_n == NL - 1));
            l_tot++;
            l_n++;
        end
    end

    task automatic wait_accept();
        int t = 0;
        @(negedge clk);
        while (!s_if.pix_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t == 1000) chk("acc_timeout", WW'(s_if.pix_ready), WW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic stall();
        logic [WW-1:0] held;
        s_if.win_ready = 1'b0;
        held = s_if.win_out;
        chk("bp_valid", WW'(s_if.win_valid), WW'(1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_ready", WW'(s_if.pix_ready), WW'(0));
            chk("bp_hold", s_if.win_out, held);
            @(posedge clk);
            #1;
        end
        s_if.win_ready = 1'b1;
    endtask

    task automatic send_frame(input int f, input int stall_at);
        for (int i = 0; i < SW * SH; i++) begin
            s_if.pix_in    = ramp(i / SW, i % SW, f);
            s_if.pix_valid = 1'b1;
            wait_accept();
            if (chk_lat && i == 35) chk("lat_pre", WW'(s_if.win_valid), WW'(0));
            if (chk_lat && i == 36) begin
                chk("lat_valid", WW'(s_if.win_valid), WW'(1));
                chk("lat_row", WW'(s_if.win_row), WW'(0));
                chk("lat_col", WW'(s_if.win_col), WW'(0));
                chk("el0", WW'(s_if.win_out[23:0]), WW'(24'h000000));
                chk("el24", WW'(s_if.win_out[24*24 +: 24]), WW'(24'h040400));
            end
            if (i == stall_at) stall();
        end
        s_if.pix_valid = 1'b0;
    endtask

    task automatic clear_mon();
        s_n = 0;
        s_f = 0;
        s_tot = 0;
        s_fd = 0;
    endtask

    initial begin
        int c0;
        s_if.pix_in    = 24'habcdef;
        s_if.pix_valid = 1'b1;
        s_if.win_ready = 1'b1;
        l_if.pix_in    = 24'h808080;
        l_if.pix_valid = 1'b0;
        l_if.win_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_valid", WW'(s_if.win_valid), WW'(0));
        chk("rst_fdone", WW'(s_if.frame_done), WW'(0));
        chk("rst_row", WW'(s_if.win_row), WW'(0));
        chk("rst_col", WW'(s_if.win_col), WW'(0));
        chk("rst_win", s_if.win_out, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_if.pix_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", WW'(s_if.pix_ready), WW'(1));
        @(posedge clk);
        #1;

        clear_mon();
        mon_s = 1;
        chk_lat = 1;
        send_frame(0, -1);
        chk_lat = 0;
        repeat (3) @(negedge clk);
        chk("ramp_nwin", WW'(s_tot), WW'(NS));
        chk("ramp_fd", WW'(s_fd), WW'(1));
        @(posedge clk);
        #1;

        clear_mon();
        send_frame(0, 39);
        repeat (3) @(negedge clk);
        chk("bp_nwin", WW'(s_tot), WW'(NS));
        chk("bp_fd", WW'(s_fd), WW'(1));
        @(posedge clk);
        #1;

        mon_s = 0;
        for (int i = 0; i < 100; i++) begin
            s_if.pix_in    = 24'(i * 32'h010203);
            s_if.pix_valid = 1'b1;
            wait_accept();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mr_valid", WW'(s_if.win_valid), WW'(0));
        chk("mr_row", WW'(s_if.win_row), WW'(0));
        chk("mr_col", WW'(s_if.win_col), WW'(0));
        chk("mr_win", s_if.win_out, '0);
        s_if.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_mon();
        mon_s = 1;
        send_frame(0, -1);
        repeat (3) @(negedge clk);
        chk("mr_nwin", WW'(s_tot), WW'(NS));
        chk("mr_fd", WW'(s_fd), WW'(1));
        @(posedge clk);
        #1;

        clear_mon();
        c0 = cyc;
        send_frame(0, -1);
        send_frame(1, -1);
        chk("b2b_cyc", WW'(cyc - c0), WW'(2 * SW * SH));
        repeat (3) @(negedge clk);
        chk("b2b_nwin", WW'(s_tot), WW'(2 * NS));
        chk("b2b_fd", WW'(s_fd), WW'(2));
        mon_s = 0;
        @(posedge clk);
        #1;

        mon_l = 1;
        l_if.pix_valid = 1'b1;
        repeat (LD * LD) @(posedge clk);
        #1;
        l_if.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("l_nwin", WW'(l_tot), WW'(NL));
        chk("l_fd", WW'(l_fd), WW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
